// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: op codes, bus widths, state encoding and op-decode helpers for the memory stage
package mem_stage_pkg;
  localparam int AluOpBus = 8;
  localparam int RegBus = 32;
  localparam logic RstEnable = 1'b1;
  typedef logic [AluOpBus-1:0] alu_op_t;
  typedef logic [RegBus-1:0] reg_t;
  localparam alu_op_t EXE_ADD_OP = 8'b0010_0000;
  localparam alu_op_t EXE_OR_OP  = 8'b0010_0101;
  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  function automatic logic is_store(alu_op_t op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_mem(alu_op_t op);
    return is_store(op) || (op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP});
  endfunction
  function automatic logic [1:0] last_idx(alu_op_t op);
    return (op inside {EXE_LW_OP, EXE_SW_OP}) ? 2'd3 :
           (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? 2'd1 : 2'd0;
  endfunction
  function automatic logic misaligned(alu_op_t op, logic [1:0] a);
    return ((op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) && a[0]) ||
           ((op inside {EXE_LW_OP, EXE_SW_OP}) && a != 2'd0);
  endfunction
endpackage

// File: rtl/mem_stage_ld_ext.sv
// mem_ld_ext: picks the loaded bytes and sign/zero extends them according to the load op
module mem_ld_ext
  import mem_stage_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] word,
  output logic [31:0] data
);
  // byte/half/word selection with extension
  always_comb begin
    data = word;
    data = (op == EXE_LB_OP)  ? {{24{word[7]}}, word[7:0]} :
           (op == EXE_LBU_OP) ? {24'd0, word[7:0]} :
           (op == EXE_LH_OP)  ? {{16{word[15]}}, word[15:0]} :
           (op == EXE_LHU_OP) ? {16'd0, word[15:0]} : word;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage over an 8-bit RAM; MEM_MISALIGN_CHK_EN enables alignment trapping
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  alu_op_t               aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           wData_i,
  input  logic [4:0]            wAddr_i,
  input  logic                  wreg_i,
  input  logic [7:0]            ram_din_i,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  output logic [4:0]            wAddr_o,
  output logic [31:0]           wData_o,
  output logic                  wreg_o,
  output logic                  stall_req_o,
  output logic                  misalign_o
);
  state_t state, state_n;
  alu_op_t op;
  logic [31:0] addr, data, ld_word, ext;
  logic [4:0] waddr;
  logic wreg, mis, bad, accept, pass, done, last;
  logic [1:0] idx, cap_idx;
`ifdef MEM_MISALIGN_CHK_EN
  assign bad = misaligned(aluop_i, mem_addr_i[1:0]);
  assign misalign_o = done && mis;
`else
  assign bad = 1'b0;
  assign misalign_o = 1'b0;
`endif
  assign accept = !rst && state == IDLE && req_i && is_mem(aluop_i);
  assign pass = !rst && state == IDLE && req_i && !is_mem(aluop_i);
  assign done = state == DONE;
  assign last = idx == last_idx(op);
  assign cap_idx = (state == WAIT) ? idx : idx - 2'd1;
  mem_ld_ext u_ext (.op(op), .word(ld_word), .data(ext));
  // next state: misaligned accesses skip straight to DONE, stores skip WAIT
  always_comb begin
    state_n = state;
    state_n = (state == IDLE)   ? (accept ? (bad ? DONE : ACCESS) : IDLE) :
              (state == ACCESS) ? (last ? (is_store(op) ? DONE : WAIT) : ACCESS) :
              (state == WAIT)   ? DONE : IDLE;
  end
  // state, latched instruction, byte counter and load assembly; a load byte arrives one cycle after its address
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      data <= '0;
      waddr <= '0;
      wreg <= 1'b0;
      idx <= '0;
      ld_word <= '0;
      mis <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= aluop_i;
        addr <= mem_addr_i;
        data <= wData_i;
        waddr <= wAddr_i;
        wreg <= wreg_i;
        idx <= '0;
        ld_word <= '0;
        mis <= bad;
      end
      if (state == ACCESS && !last)
        idx <= idx + 2'd1;
      if (!is_store(op) && ((state == ACCESS && idx != 2'd0) || state == WAIT))
        ld_word[{cap_idx, 3'b000} +: 8] <= ram_din_i;
    end
  end
  assign ram_addr_o = (state == ACCESS) ? RAM_ADDR_W'(addr + 32'(idx)) : '0;
  assign ram_wr_o = state == ACCESS && is_store(op);
  assign ram_dout_o = ram_wr_o ? data[{idx, 3'b000} +: 8] : '0;
  assign stall_req_o = accept || state == ACCESS || state == WAIT;
  assign wAddr_o = done ? waddr : pass ? wAddr_i : '0;
  assign wData_o = done ? ext : pass ? wData_i : '0;
  assign wreg_o = done ? (wreg && !is_store(op) && !mis) : (pass && wreg_i);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of loads, stores, pass-through, reset abort and misalignment
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, wreg = 1'b0;
  alu_op_t aluop = '0;
  logic [31:0] maddr = '0, wdata = '0;
  logic [4:0] waddr = '0;
  logic [7:0] ram_din, ram_dout;
  logic [16:0] ram_addr;
  logic ram_wr, wreg_o, stall, mis;
  logic [4:0] wAddr_o;
  logic [31:0] wData_o;
  logic [7:0] ram [0:131071];
  logic ld_en = 1'b0;
  logic [16:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .req_i(req), .aluop_i(aluop), .mem_addr_i(maddr),
    .wData_i(wdata), .wAddr_i(waddr), .wreg_i(wreg), .ram_din_i(ram_din),
    .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr),
    .wAddr_o(wAddr_o), .wData_o(wData_o), .wreg_o(wreg_o),
    .stall_req_o(stall), .misalign_o(mis)
  );
  always @(posedge clk) begin
    ram_din <= ram[ram_addr];
    if (ram_wr) ram[ram_addr] <= ram_dout;
    if (ld_en) ram[ld_a] <= ld_d;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic nx;
    @(negedge clk);
  endtask
  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    ld_a = a; ld_d = d; ld_en = 1'b1;
    nx();
    ld_en = 1'b0;
  endtask
  task automatic drive(input logic r, input alu_op_t o, input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa, input logic w);
    req = r; aluop = o; maddr = a; wdata = d; waddr = wa; wreg = w;
  endtask
  initial begin
    poke(17'h100, 8'h78); poke(17'h101, 8'h56); poke(17'h102, 8'h34); poke(17'h103, 8'h12);
    poke(17'h104, 8'h9A); poke(17'h300, 8'h80); poke(17'h401, 8'h00);
    drive(1, EXE_LW_OP, 32'h100, 0, 5, 1);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_wr", ram_wr, 1'b0);
    chk("rst_addr", ram_addr, 17'h0);
    chk("rst_wreg", wreg_o, 1'b0);
    chk("rst_mis", mis, 1'b0);
    nx(); rst = 1'b0; #1;
    chk("lw_T_stall", stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      chk("lw_addr", ram_addr, 17'h100 + 17'(k));
      chk("lw_stall", stall, 1'b1);
      chk("lw_wr", ram_wr, 1'b0);
    end
    nx(); #1;
    chk("lw_wait_stall", stall, 1'b1);
    chk("lw_wait_wreg", wreg_o, 1'b0);
    nx(); #1;
    chk("lw_done_data", wData_o, 32'h12345678);
    chk("lw_done_wreg", wreg_o, 1'b1);
    chk("lw_done_waddr", wAddr_o, 5'd5);
    chk("lw_done_stall", stall, 1'b0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("idle_wreg", wreg_o, 1'b0);
    chk("idle_wdata", wData_o, 32'h0);
    chk("idle_stall", stall, 1'b0);
    nx(); drive(1, EXE_SH_OP, 32'h202, 32'hFFFFABCD, 7, 1); #1;
    chk("sh_T_stall", stall, 1'b1);
    nx(); #1;
    chk("sh_wr1", ram_wr, 1'b1);
    chk("sh_addr1", ram_addr, 17'h202);
    chk("sh_dout1", ram_dout, 8'hCD);
    nx(); #1;
    chk("sh_wr2", ram_wr, 1'b1);
    chk("sh_addr2", ram_addr, 17'h203);
    chk("sh_dout2", ram_dout, 8'hAB);
    nx(); #1;
    chk("sh_done_wr", ram_wr, 1'b0);
    chk("sh_done_wreg", wreg_o, 1'b0);
    chk("sh_done_stall", stall, 1'b0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("sh_mem0", ram[17'h202], 8'hCD);
    chk("sh_mem1", ram[17'h203], 8'hAB);
    nx(); drive(1, EXE_LB_OP, 32'h300, 0, 2, 1);
    nx(); #1;
    chk("lb_addr", ram_addr, 17'h300);
    nx(); #1;
    chk("lb_wait_stall", stall, 1'b1);
    nx(); #1;
    chk("lb_data", wData_o, 32'hFFFFFF80);
    nx(); drive(1, EXE_LBU_OP, 32'h300, 0, 2, 1);
    nx(); nx(); nx(); #1;
    chk("lbu_data", wData_o, 32'h00000080);
    chk("lbu_wreg", wreg_o, 1'b1);
    nx(); drive(1, EXE_ADD_OP, 0, 32'h5, 3, 1); #1;
    chk("add_data", wData_o, 32'h5);
    chk("add_wreg", wreg_o, 1'b1);
    chk("add_waddr", wAddr_o, 5'd3);
    chk("add_stall", stall, 1'b0);
    nx(); drive(1, EXE_LW_OP, 32'h100, 0, 9, 1); #1;
    chk("lw2_T_stall", stall, 1'b1);
    repeat (6) nx();
    #1;
    chk("lw2_done_data", wData_o, 32'h12345678);
    chk("lw2_done_waddr", wAddr_o, 5'd9);
    chk("lw2_done_stall", stall, 1'b0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("lw2_no_reaccept_addr", ram_addr, 17'h0);
    chk("lw2_no_reaccept_stall", stall, 1'b0);
    nx(); drive(1, EXE_SW_OP, 32'h400, 32'h11223344, 0, 0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("sw_a_dout1", ram_dout, 8'h44);
    nx(); #1;
    chk("sw_a_addr2", ram_addr, 17'h401);
    rst = 1'b1; #1;
    chk("sw_a_rst_wr", ram_wr, 1'b0);
    chk("sw_a_rst_stall", stall, 1'b0);
    chk("sw_a_rst_addr", ram_addr, 17'h0);
    nx(); rst = 1'b0; #1;
    chk("sw_a_mem0", ram[17'h400], 8'h44);
    chk("sw_a_mem1", ram[17'h401], 8'h00);
    drive(1, EXE_SW_OP, 32'h400, 32'hAABBCCDD, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      chk("sw_wr", ram_wr, 1'b1);
      chk("sw_addr", ram_addr, 17'h400 + 17'(k));
    end
    nx(); #1;
    chk("sw_done_wr", ram_wr, 1'b0);
    chk("sw_done_stall", stall, 1'b0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("sw_mem0", ram[17'h400], 8'hDD);
    chk("sw_mem3", ram[17'h403], 8'hAA);
    nx(); drive(1, EXE_LW_OP, 32'h101, 0, 4, 1); #1;
    chk("mis_T_stall", stall, 1'b1);
`ifdef MEM_MISALIGN_CHK_EN
    nx(); #1;
    chk("mis_pulse", mis, 1'b1);
    chk("mis_wreg", wreg_o, 1'b0);
    chk("mis_addr", ram_addr, 17'h0);
    chk("mis_wr", ram_wr, 1'b0);
    chk("mis_stall", stall, 1'b0);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0); #1;
    chk("mis_pulse_end", mis, 1'b0);
`else
    for (int k = 0; k < 4; k++) begin
      nx(); #1;
      chk("mis_addr", ram_addr, 17'h101 + 17'(k));
      chk("mis_flag", mis, 1'b0);
    end
    nx(); nx(); #1;
    chk("mis_data", wData_o, 32'h9A123456);
    nx(); drive(0, EXE_ADD_OP, 0, 0, 0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
